maxpool_window_ctrl: RTL and testbench
======================================

# maxpool_window_ctrl

Sequencer that streams a feature map stored in a single-port read memory through the 2x2 max-pooling datapath. It writes one pooled word per window to an output memory. It sits between the layer buffer memories and the pooling datapath. It walks 2x2 windows in raster order, gathers the four operands and keeps the datapath pipeline enabled. It tracks in-flight windows with a valid shift register and signals completion to the layer scheduler.

## Interface
Parameters:
- DATA_W, 32, word width of feature-map elements
- ADDR_W, 16, memory address width
- DIM_W, 10, width of map height/width configuration fields
- POOL_LAT, 3, clock edges from datapath sampling its inputs to pool_out valid

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; ignored while busy
- cfg_width  in  DIM_W  input map width in elements, latched on start
- cfg_height  in  DIM_W  input map height in rows, latched on start
- cfg_in_base  in  ADDR_W  input map base address, latched on start
- cfg_out_base  in  ADDR_W  output map base address, latched on start
- busy  out  1  high from the cycle after accepted start through the last write
- done  out  1  one-cycle pulse after the final write, or after start with zero windows
- rd_en  out  1  input memory read strobe
- rd_addr  out  ADDR_W  input memory address
- rd_data  in  DATA_W  read data, valid exactly one cycle after rd_en
- pool_en  out  1  datapath clock enable, high whenever busy
- pool_in1..pool_in4  out  DATA_W each  registered window operands: top-left, top-right, bottom-left, bottom-right
- pool_out  in  DATA_W  datapath result
- wr_en  out  1  output memory write strobe
- wr_addr  out  ADDR_W  output memory address
- wr_data  out  DATA_W  equals pool_out

## Operation
- States:
  - IDLE to RD on accepted start, or to FIN if windows = 0.
  - RD issues reads; phase counter 0..3. Leaves to DRAIN after phase 3 of the last window.
  - DRAIN waits until the valid shift register is empty, then goes to FIN.
  - FIN asserts done for one cycle and returns to IDLE.
- Window grid: OW = cfg_width>>1, OH = cfg_height>>1. An odd last column or row is dropped. Windows = OW*OH, so cfg_width<2 or cfg_height<2 gives zero windows.
- Window (i,j) has top-left element A = in_base + 2i*W + 2j. Phases 0..3 read A, A+1, A+W, A+W+1. Address arithmetic is modulo 2^ADDR_W.
- Each returned word is captured into a staging register. After the phase-3 data returns, all four staging registers are copied to pool_in1..4 in one edge. A 1 is injected into a POOL_LAT-deep valid shift register at the same edge.
- wr_en is the shift-register output. wr_addr = out_base + k, where k is the write counter 0..Windows-1, raster order.
- Reads are back-to-back across windows, giving one window every 4 cycles with no bubbles.
- Reset state:
  - IDLE; busy=0, done=0, rd_en=0, wr_en=0, pool_en=0.
  - rd_addr, wr_addr, pool_in1..4 = 0; valid shift register cleared.
- rst mid-operation aborts immediately. No further reads or writes, no done pulse. In-flight results are discarded.
- start while busy or while done is asserted is ignored, and the configuration is not relatched.

## Timing
- Cycle 0: start sampled high.
- Window k: rd_en in cycles 1+4k..4+4k; rd_data in cycles 2+4k..5+4k; pool_in1..4 valid from cycle 6+4k.
- wr_en for window k in cycle 6+4k+POOL_LAT, which is cycle 9+4k at the default latency.
- done in cycle 7+4(N-1)+POOL_LAT for N windows, and busy is low in that cycle. With zero windows, done is in cycle 1 and busy never rises.
- pool_in1..4 hold their values between updates.

## Structure
- Shared package pool_pkg: the state enum (IDLE, RD, DRAIN, FIN) and the default DATA_W/ADDR_W/POOL_LAT constants, shared with the pooling datapath.
- Sub-module pool_addr_gen holds the (i,j) window counters, the phase counter, the row-offset accumulator and the rd_addr/last-window flag. The FSM, staging registers, valid shift register and write counter stay in the top.

## Test plan
- 2x2 map, base 0x0100, data 5,9,2,7 -> reads 0x100,0x101,0x102,0x103 in cycles 1-4; pool_in = 5,9,2,7 in cycle 6; single write in cycle 9 to out_base; done in cycle 10.
- 4x4 map holding 0..15 row-major -> 4 writes in cycles 9,13,17,21 of values 5,7,13,15 to out_base+0..3; done in cycle 22.
- 5x3 map -> OW=2, OH=1; reads for window 1 are base+2, +3, +7, +8; exactly 2 writes; row 2 and column 4 are never read.
- cfg_width=1, height=8 -> no rd_en, no wr_en; done in cycle 1.
- 4x4 run with rst asserted in cycle 12 -> outputs at reset values from cycle 13; no wr_en after cycle 12; no done.
- start re-pulsed in cycle 5 of a 2x2 run with different cfg -> ignored; addresses and write count unchanged.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and defaults for the 2x2 max-pooling engine.
// Used by the window sequencer and the pooling datapath.
package pool_pkg;

  localparam int DATA_W_D   = 32;
  localparam int ADDR_W_D   = 16;
  localparam int POOL_LAT_D = 3;

  localparam logic [1:0] PH_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window/phase walker for the max-pool sequencer.
// Produces the registered read address and the last-window flag.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DIM_W-1:0]  i_width,
  input  logic [DIM_W-1:0]  i_ow,
  input  logic [DIM_W-1:0]  i_oh,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_phase,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] A1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A2 = ADDR_W'(2);
  localparam logic [DIM_W-1:0]  D1 = DIM_W'(1);

  logic [ADDR_W-1:0] r_w;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_addr;
  logic [DIM_W-1:0]  r_ow;
  logic [DIM_W-1:0]  r_oh;
  logic [DIM_W-1:0]  r_i;
  logic [DIM_W-1:0]  r_j;
  logic [1:0]        r_phase;

  logic [ADDR_W-1:0] w_col2;
  logic [ADDR_W-1:0] w_a;
  logic [ADDR_W-1:0] w_w2;
  logic [ADDR_W-1:0] w_row_nx;
  logic              w_last_col;
  logic              w_last_row;

  // r_row tracks in_base + 2*i*W so no multiplier is needed
  assign w_col2     = ADDR_W'({r_j, 1'b0});
  assign w_a        = r_row + w_col2;
  assign w_w2       = r_w << 1;
  assign w_row_nx   = r_row + w_w2;
  assign w_last_col = (r_j == r_ow - D1);
  assign w_last_row = (r_i == r_oh - D1);

  assign o_addr  = r_addr;
  assign o_phase = r_phase;
  assign o_last  = w_last_col && w_last_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w     <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_ow    <= '0;
      r_oh    <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_phase <= '0;
    end else if (i_load) begin
      r_w     <= ADDR_W'(i_width);
      r_ow    <= i_ow;
      r_oh    <= i_oh;
      r_i     <= '0;
      r_j     <= '0;
      r_phase <= '0;
      r_row   <= i_base;
      r_addr  <= i_base;
    end else if (i_step) begin
      r_phase <= r_phase + 2'd1;
      unique case (r_phase)
        2'd0: r_addr <= w_a + A1;
        2'd1: r_addr <= w_a + r_w;
        2'd2: r_addr <= w_a + r_w + A1;
        default: begin
          if (w_last_col) begin
            r_j    <= '0;
            r_i    <= r_i + D1;
            r_row  <= w_row_nx;
            r_addr <= w_row_nx;
          end else begin
            r_j    <= r_j + D1;
            r_addr <= w_a + A2;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/maxpool_window_ctrl.sv
// 2x2 max-pool window sequencer: reads operands, feeds the
// pooling datapath and writes one result word per window.
module maxpool_window_ctrl
  import pool_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DIM_W    = 10,
  parameter int POOL_LAT = POOL_LAT_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pool_en,
  output logic [DATA_W-1:0] pool_in1,
  output logic [DATA_W-1:0] pool_in2,
  output logic [DATA_W-1:0] pool_in3,
  output logic [DATA_W-1:0] pool_in4,
  input  logic [DATA_W-1:0] pool_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] A1 = ADDR_W'(1);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_pool_en;
  logic [ADDR_W-1:0] r_out_base;

  logic              r_rd_vld;
  logic [1:0]        r_rd_ph;
  logic [DATA_W-1:0] r_stg0;
  logic [DATA_W-1:0] r_stg1;
  logic [DATA_W-1:0] r_stg2;
  logic [DATA_W-1:0] r_pin1;
  logic [DATA_W-1:0] r_pin2;
  logic [DATA_W-1:0] r_pin3;
  logic [DATA_W-1:0] r_pin4;
  logic [POOL_LAT-1:0] r_vsr;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_wr_cnt;

  logic [DIM_W-1:0]  w_ow;
  logic [DIM_W-1:0]  w_oh;
  logic              w_zero;
  logic              w_accept;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_end_rd;
  logic              w_inject;
  logic [1:0]        w_phase;
  logic [POOL_LAT-1:0] w_inj_vec;

  assign w_ow     = cfg_width >> 1;
  assign w_oh     = cfg_height >> 1;
  assign w_zero   = (w_ow == '0) || (w_oh == '0);
  assign w_accept = start && (r_state == IDLE);
  assign w_load   = w_accept && !w_zero;
  assign w_end_rd = (w_phase == PH_LAST) && w_last;
  assign w_step   = (r_state == RD) && !w_end_rd;
  assign w_inject = r_rd_vld && (r_rd_ph == PH_LAST);

  always_comb begin
    w_inj_vec    = '0;
    w_inj_vec[0] = w_inject;
  end

  pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_width (cfg_width),
    .i_ow    (w_ow),
    .i_oh    (w_oh),
    .i_base  (cfg_in_base),
    .o_addr  (rd_addr),
    .o_phase (w_phase),
    .o_last  (w_last)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_en    = r_rd_en;
  assign pool_en  = r_pool_en;
  assign pool_in1 = r_pin1;
  assign pool_in2 = r_pin2;
  assign pool_in3 = r_pin3;
  assign pool_in4 = r_pin4;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = pool_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_pool_en  <= 1'b0;
      r_out_base <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_out_base <= cfg_out_base;
            if (w_zero) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state   <= RD;
              r_busy    <= 1'b1;
              r_pool_en <= 1'b1;
              r_rd_en   <= 1'b1;
            end
          end
        end
        RD: begin
          if (w_end_rd) begin
            r_state <= DRAIN;
            r_rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          // a read still returning will inject into the pipe
          if (!r_rd_vld && (r_vsr == '0)) begin
            r_state   <= FIN;
            r_busy    <= 1'b0;
            r_pool_en <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_ph  <= '0;
      r_stg0   <= '0;
      r_stg1   <= '0;
      r_stg2   <= '0;
      r_pin1   <= '0;
      r_pin2   <= '0;
      r_pin3   <= '0;
      r_pin4   <= '0;
      r_vsr    <= '0;
    end else begin
      r_rd_vld <= r_rd_en;
      r_rd_ph  <= w_phase;
      r_vsr    <= (r_vsr << 1) | w_inj_vec;
      if (r_rd_vld) begin
        unique case (r_rd_ph)
          2'd0: r_stg0 <= rd_data;
          2'd1: r_stg1 <= rd_data;
          2'd2: r_stg2 <= rd_data;
          default: begin
            r_pin1 <= r_stg0;
            r_pin2 <= r_stg1;
            r_pin3 <= r_stg2;
            r_pin4 <= rd_data;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_cnt  <= '0;
    end else begin
      r_wr_en <= r_vsr[POOL_LAT-1];
      if (w_accept) begin
        r_wr_cnt <= '0;
      end else if (r_vsr[POOL_LAT-1]) begin
        r_wr_addr <= r_out_base + r_wr_cnt;
        r_wr_cnt  <= r_wr_cnt + A1;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Self-checking bench for maxpool_window_ctrl with a memory
// model, a max-of-four datapath model and a window reference.
module tb_maxpool_window_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int DMW = 10;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [DMW-1:0] cfg_width = '0;
  logic [DMW-1:0] cfg_height = '0;
  logic [AW-1:0]  cfg_in_base = '0;
  logic [AW-1:0]  cfg_out_base = '0;
  logic           busy, done, rd_en, pool_en, wr_en;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic [DW-1:0]  rd_data = '0;
  logic [DW-1:0]  pool_in1, pool_in2, pool_in3, pool_in4;
  logic [DW-1:0]  pool_out, wr_data;

  always #5 clk = ~clk;

  maxpool_window_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .DIM_W(DMW), .POOL_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_en(pool_en),
    .pool_in1(pool_in1), .pool_in2(pool_in2),
    .pool_in3(pool_in3), .pool_in4(pool_in4),
    .pool_out(pool_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic logic [DW-1:0] max4(
    input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  logic [DW-1:0] pp [0:LAT-1];
  always @(posedge clk) begin
    pp[0] <= max4(pool_in1, pool_in2, pool_in3, pool_in4);
    for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
  end
  assign pool_out = pp[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  typedef struct {
    int            w;
    int            h;
    logic [AW-1:0] ib;
    logic [AW-1:0] ob;
    int            exp_n;
    int            exp_done;
  } vec_t;

  int            t0 = 0;
  ev_t           rd_q[$];
  ev_t           wr_q[$];
  int            done_q[$];
  logic          busy_any;
  logic          busy_at [0:2047];
  logic [4*DW-1:0] pin6;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    int rel;
    @(negedge clk);
    rel = cyc - t0;
    if (rd_en) rd_q.push_back('{c: rel, a: rd_addr, d: '0});
    if (wr_en) wr_q.push_back('{c: rel, a: wr_addr, d: wr_data});
    if (done) done_q.push_back(rel);
    if (busy) busy_any = 1'b1;
    if (rel >= 0 && rel < 2048) busy_at[rel] = busy;
    if (rel == 6) pin6 = {pool_in1, pool_in2, pool_in3, pool_in4};
  endtask

  task automatic launch(input int w, input int h,
                        input logic [AW-1:0] ib,
                        input logic [AW-1:0] ob);
    tick();
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    busy_any = 1'b0;
    for (int i = 0; i < 2048; i++) busy_at[i] = 1'b0;
    pin6 = '0;
    cfg_width    = DMW'(w);
    cfg_height   = DMW'(h);
    cfg_in_base  = ib;
    cfg_out_base = ob;
    t0    = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run();
    int k;
    k = 0;
    while (done_q.size() == 0 && k < 3000) begin
      tick();
      k++;
    end
    repeat (6) tick();
  endtask

  function automatic logic [AW-1:0] wadr(
    input logic [AW-1:0] ib, input int w,
    input int i, input int j, input int p);
    int off;
    off = 2*i*w + 2*j + ((p >= 2) ? w : 0) + (p % 2);
    return AW'(int'(ib) + off);
  endfunction

  task automatic check_model(input string nm,
                             input int w, input int h,
                             input logic [AW-1:0] ib,
                             input logic [AW-1:0] ob);
    int ow, oh, n, k, ed;
    logic [AW-1:0] ea;
    logic [DW-1:0] ev;
    ow = w / 2;
    oh = h / 2;
    n  = ow * oh;
    chk({nm, " rd_count"}, rd_q.size(), 4*n);
    chk({nm, " wr_count"}, wr_q.size(), n);
    k = 0;
    for (int i = 0; i < oh; i++) begin
      for (int j = 0; j < ow; j++) begin
        for (int p = 0; p < 4; p++) begin
          ea = wadr(ib, w, i, j, p);
          if (4*k + p < rd_q.size())
            chk($sformatf("%s rd%0d cyc_addr", nm, 4*k+p),
                {32'(rd_q[4*k+p].c), 16'h0, rd_q[4*k+p].a},
                {32'(1 + 4*k + p), 16'h0, ea});
        end
        ev = max4(mem[wadr(ib, w, i, j, 0)],
                  mem[wadr(ib, w, i, j, 1)],
                  mem[wadr(ib, w, i, j, 2)],
                  mem[wadr(ib, w, i, j, 3)]);
        if (k < wr_q.size()) begin
          chk($sformatf("%s wr%0d cyc_addr", nm, k),
              {32'(wr_q[k].c), 16'h0, wr_q[k].a},
              {32'(6 + 4*k + LAT), 16'h0, AW'(int'(ob) + k)});
          chk($sformatf("%s wr%0d data", nm, k), wr_q[k].d, ev);
        end
        k++;
      end
    end
    ed = (n == 0) ? 1 : 7 + 4*(n-1) + LAT;
    chk({nm, " done_count"}, done_q.size(), 1);
    if (done_q.size() > 0)
      chk({nm, " done_cycle"}, done_q[0], ed);
    chk({nm, " busy_at_done"}, busy_at[ed], 0);
    chk({nm, " busy_any"}, busy_any, (n > 0));
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " rd_en"}, rd_en, 0);
    chk({nm, " wr_en"}, wr_en, 0);
    chk({nm, " pool_en"}, pool_en, 0);
    chk({nm, " rd_addr"}, rd_addr, 0);
    chk({nm, " wr_addr"}, wr_addr, 0);
    chk({nm, " pool_in"},
        {pool_in1, pool_in2, pool_in3, pool_in4}, 0);
  endtask

  vec_t tbl [6];

  initial begin
    int cnt;
    logic [DW-1:0] exp4 [4];
    tbl[0] = '{2, 2, 16'h0100, 16'h0200, 1, 10};
    tbl[1] = '{4, 4, 16'h0400, 16'h0800, 4, 22};
    tbl[2] = '{5, 3, 16'h1000, 16'h1100, 2, 14};
    tbl[3] = '{1, 8, 16'h2000, 16'h2100, 0, 1};
    tbl[4] = '{8, 1, 16'h3000, 16'h3100, 0, 1};
    tbl[5] = '{7, 5, 16'hFFF0, 16'hFFFE, 6, 30};

    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16'h0100] = 5;
    mem[16'h0101] = 9;
    mem[16'h0102] = 2;
    mem[16'h0103] = 7;
    for (int i = 0; i < 16; i++) mem[16'h0400 + i] = DW'(i);

    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      launch(tbl[v].w, tbl[v].h, tbl[v].ib, tbl[v].ob);
      finish_run();
      chk($sformatf("tbl%0d n_writes", v), wr_q.size(),
          tbl[v].exp_n);
      if (done_q.size() > 0)
        chk($sformatf("tbl%0d done_at", v), done_q[0],
            tbl[v].exp_done);
      check_model($sformatf("tbl%0d", v), tbl[v].w,
                  tbl[v].h, tbl[v].ib, tbl[v].ob);
    end

    // 2x2 operands land on pool_in in cycle 6 and then hold
    launch(2, 2, 16'h0100, 16'h0200);
    finish_run();
    chk("2x2 pool_in@6", pin6, {32'd5, 32'd9, 32'd2, 32'd7});
    chk("2x2 pool_in_hold",
        {pool_in1, pool_in2, pool_in3, pool_in4},
        {32'd5, 32'd9, 32'd2, 32'd7});
    if (wr_q.size() > 0) begin
      chk("2x2 wr_data", wr_q[0].d, 9);
      chk("2x2 wr_addr", wr_q[0].a, 16'h0200);
      chk("2x2 wr_cycle", wr_q[0].c, 9);
    end

    exp4 = '{32'd5, 32'd7, 32'd13, 32'd15};
    launch(4, 4, 16'h0400, 16'h0800);
    finish_run();
    for (int k = 0; k < 4; k++) begin
      if (k < wr_q.size()) begin
        chk($sformatf("4x4 wr%0d data", k), wr_q[k].d, exp4[k]);
        chk($sformatf("4x4 wr%0d cyc", k), wr_q[k].c, 9 + 4*k);
      end
    end

    launch(5, 3, 16'h1000, 16'h1100);
    finish_run();
    if (rd_q.size() == 8) begin
      chk("5x3 w1 rd0", rd_q[4].a, 16'h1002);
      chk("5x3 w1 rd3", rd_q[7].a, 16'h1008);
    end
    cnt = 0;
    foreach (rd_q[x]) begin
      if ((rd_q[x].a - 16'h1000) % 5 == 4 ||
          (rd_q[x].a - 16'h1000) >= 10) cnt++;
    end
    chk("5x3 stray_reads", cnt, 0);

    launch(4, 4, 16'h0400, 16'h0800);
    while (cyc - t0 < 12) tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("abort");
    rst = 1'b0;
    repeat (20) tick();
    chk("abort wr_count", wr_q.size(), 1);
    chk("abort done_count", done_q.size(), 0);
    cnt = 0;
    foreach (rd_q[x]) if (rd_q[x].c > 12) cnt++;
    chk("abort late_reads", cnt, 0);

    launch(2, 2, 16'h0100, 16'h0200);
    while (cyc - t0 < 5) tick();
    cfg_width    = DMW'(4);
    cfg_height   = DMW'(4);
    cfg_in_base  = 16'h0400;
    cfg_out_base = 16'h0900;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run();
    check_model("restart_busy", 2, 2, 16'h0100, 16'h0200);

    launch(2, 2, 16'h0100, 16'h0200);
    while (cyc - t0 < 10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("restart_done rd_count", rd_q.size(), 4);
    chk("restart_done done_count", done_q.size(), 1);

    for (int r = 0; r < 20; r++) begin
      int w, h;
      logic [AW-1:0] ib, ob;
      w  = $urandom_range(0, 11);
      h  = $urandom_range(0, 11);
      ib = AW'($urandom);
      ob = AW'($urandom);
      launch(w, h, ib, ob);
      finish_run();
      check_model($sformatf("rnd%0d", r), w, h, ib, ob);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
